cfg_regbank: RTL

CFG_REGBANK -- requirements
Module: cfg_regbank

---
 rtl/cfg_regbank_pkg.sv | 41 ++++
 rtl/cfg_regbank_irq.sv | 56 +++++
 rtl/cfg_regbank.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cfg_regbank_pkg.sv
// Shared definitions for the configuration register bank: word offsets of the
// special registers (relative to N_CTRL_WORDS) and the address region decoder.
package cfg_regbank_pkg;

    // Offsets of the fixed registers, counted from the first word after CTRL
    localparam logic [63:0] OFS_CMD  = 64'd0;
    localparam logic [63:0] OFS_IRQS = 64'd1;
    localparam logic [63:0] OFS_IRQM = 64'd2;
    localparam logic [63:0] OFS_STAT = 64'd3;

    typedef enum logic [2:0] {
        CTRL    = 3'd0,
        CMD     = 3'd1,
        IRQS    = 3'd2,
        IRQM    = 3'd3,
        STAT    = 3'd4,
        INVALID = 3'd5
    } region_e;

    // Map a word address onto the register region it falls in
    function automatic region_e decode_region(input logic [63:0] addr,
                                              input logic [63:0] n_ctrl,
                                              input logic [63:0] n_stat);
        region_e r;
        if (addr < n_ctrl) begin
            r = CTRL;
        end else if (addr == n_ctrl + OFS_CMD) begin
            r = CMD;
        end else if (addr == n_ctrl + OFS_IRQS) begin
            r = IRQS;
        end else if (addr == n_ctrl + OFS_IRQM) begin
            r = IRQM;
        end else if (addr < n_ctrl + OFS_STAT + n_stat) begin
            r = STAT;
        end else begin
            r = INVALID;
        end
        return r;
    endfunction

endpackage

// File: rtl/cfg_regbank_irq.sv
// Event capture and interrupt generation: sticky W1C status, byte-writable
// mask and a registered level interrupt. Only the low N_EVT bits exist;
// the upper bits of the exported status/mask views are tied to zero.
module cfg_regbank_irq
    import cfg_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_EVT      = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [N_EVT-1:0]      evt,
    input  logic                  clr_we,
    input  logic                  mask_we,
    input  logic [N_EVT-1:0]      wbits,
    input  logic [N_EVT-1:0]      bmask,
    output logic [DATA_WIDTH-1:0] irq_status,
    output logic [DATA_WIDTH-1:0] irq_mask,
    output logic                  irq
);

    logic [N_EVT-1:0] status_d, status_q;
    logic [N_EVT-1:0] mask_d, mask_q;
    logic             irq_d, irq_q;

    // Next state: events set status (winning over a clear), mask is byte-merged
    always_comb begin
        status_d = (status_q & ~(clr_we ? wbits : {N_EVT{1'b0}})) | evt;
        mask_d   = mask_we ? ((mask_q & ~bmask) | wbits) : mask_q;
        irq_d    = |(status_q & mask_q);
    end

    // State registers with immediate clear on reset
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            status_q <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    // Zero-extend the implemented bits to full register width
    always_comb begin
        irq_status              = '0;
        irq_mask                = '0;
        irq_status[N_EVT-1:0]   = status_q;
        irq_mask[N_EVT-1:0]     = mask_q;
    end

    assign irq = irq_q;

endmodule

// File: rtl/cfg_regbank.sv
// CPU-accessible configuration register bank: control words, command strobes,
// interrupt status/mask and status words, with a one-cycle response path.
// Optional feature: define CFG_REGBANK_SHADOW_EN to route CTRL writes into
// shadow registers that are committed to ctrl_vec by CMD bit DATA_WIDTH-1.
module cfg_regbank
    import cfg_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int N_CTRL_WORDS    = 4,
    parameter int N_STAT_WORDS    = 4,
    parameter int N_EVT           = 8,
    parameter int REGISTER_STATUS = 1
) (
    input  logic                                     clk,
    input  logic                                     arst,
    output logic [N_CTRL_WORDS-1:0][DATA_WIDTH-1:0]  ctrl_vec,
    output logic [DATA_WIDTH-1:0]                    cmd_pulse,
    input  logic [N_STAT_WORDS-1:0][DATA_WIDTH-1:0]  stat_vec,
    input  logic                                     stat_en,
    input  logic [N_EVT-1:0]                         evt,
    output logic                                     irq,
    input  logic                                     req,
    input  logic                                     we,
    input  logic [ADDR_WIDTH-1:0]                    addr,
    input  logic [DATA_WIDTH/8-1:0]                  be,
    input  logic [DATA_WIDTH-1:0]                    wdata,
    output logic                                     gnt,
    output logic                                     rvalid,
    output logic [DATA_WIDTH-1:0]                    rdata,
    output logic                                     err
);

    localparam int NB = DATA_WIDTH / 8;

    logic [63:0]                                addr_ext_s;
    region_e                                    region_s;
    logic [DATA_WIDTH-1:0]                      bit_mask_s;
    logic [DATA_WIDTH-1:0]                      wdata_m_s;
    logic                                       wr_s, rd_s, bad_s;
    logic                                       ctrl_wr_s, cmd_wr_s, irqs_wr_s, irqm_wr_s;
    logic [N_CTRL_WORDS-1:0][DATA_WIDTH-1:0]    ctrl_d, ctrl_q, ctrl_src_s;
    logic [N_STAT_WORDS-1:0][DATA_WIDTH-1:0]    stat_view_s;
    logic [DATA_WIDTH-1:0]                      ctrl_rd_s, stat_rd_s, rd_val_s;
    logic [DATA_WIDTH-1:0]                      irq_status_s, irq_mask_s;
    logic [DATA_WIDTH-1:0]                      cmd_d, cmd_q;
    logic [DATA_WIDTH-1:0]                      rdata_d, rdata_q;
    logic                                       rvalid_d, rvalid_q;
    logic                                       err_d, err_q;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                          input logic [DATA_WIDTH-1:0] new_v,
                                                          input logic [DATA_WIDTH-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign addr_ext_s = 64'(addr);
    assign region_s   = decode_region(addr_ext_s, 64'(N_CTRL_WORDS), 64'(N_STAT_WORDS));
    assign wr_s       = req & we;
    assign rd_s       = req & ~we;
    assign bad_s      = (region_s == INVALID) | ((region_s == STAT) & we);
    assign ctrl_wr_s  = wr_s & (region_s == CTRL);
    assign cmd_wr_s   = wr_s & (region_s == CMD);
    assign irqs_wr_s  = wr_s & (region_s == IRQS);
    assign irqm_wr_s  = wr_s & (region_s == IRQM);
    assign wdata_m_s  = wdata & bit_mask_s;

    // Expand byte enables into a per-bit write mask
    always_comb begin
        bit_mask_s = '0;
        for (int b = 0; b < NB; b++) begin
            bit_mask_s[b*8 +: 8] = {8{be[b]}};
        end
    end

    // Status words are either snapshotted on stat_en or passed straight through
    if (REGISTER_STATUS != 0) begin : g_stat_reg
        logic [N_STAT_WORDS-1:0][DATA_WIDTH-1:0] stat_d, stat_q;

        // Take a new snapshot only when the datapath flags it
        always_comb begin
            if (stat_en) begin
                stat_d = stat_vec;
            end else begin
                stat_d = stat_q;
            end
        end

        // Snapshot register
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                stat_q <= '0;
            end else begin
                stat_q <= stat_d;
            end
        end

        assign stat_view_s = stat_q;
    end else begin : g_stat_pass
        logic stat_en_unused;
        assign stat_en_unused = stat_en;
        assign stat_view_s    = stat_vec;
    end

`ifdef CFG_REGBANK_SHADOW_EN
    logic [N_CTRL_WORDS-1:0][DATA_WIDTH-1:0] shadow_d, shadow_q;

    // Shadow registers hold pending control values until a commit command
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign ctrl_src_s = shadow_q;
`else
    assign ctrl_src_s = ctrl_q;
`endif

    // Read-side mux for the indexed CTRL and STAT word arrays
    always_comb begin
        ctrl_rd_s = '0;
        stat_rd_s = '0;
        for (int i = 0; i < N_CTRL_WORDS; i++) begin
            ctrl_rd_s = ctrl_rd_s | ((addr_ext_s == 64'(i)) ? ctrl_src_s[i] : {DATA_WIDTH{1'b0}});
        end
        for (int i = 0; i < N_STAT_WORDS; i++) begin
            stat_rd_s = stat_rd_s |
                ((addr_ext_s == 64'(N_CTRL_WORDS) + OFS_STAT + 64'(i)) ? stat_view_s[i]
                                                                      : {DATA_WIDTH{1'b0}});
        end
    end

    // Select read data by region; CMD and invalid addresses read as zero
    always_comb begin
        case (region_s)
            CTRL:    rd_val_s = ctrl_rd_s;
            CMD:     rd_val_s = '0;
            IRQS:    rd_val_s = irq_status_s;
            IRQM:    rd_val_s = irq_mask_s;
            STAT:    rd_val_s = stat_rd_s;
            INVALID: rd_val_s = '0;
            default: rd_val_s = '0;
        endcase
    end

    // Next-state for control words, command strobe and the response registers
    always_comb begin
        cmd_d    = cmd_wr_s ? wdata_m_s : {DATA_WIDTH{1'b0}};
        rvalid_d = req;
        err_d    = req & bad_s;
        rdata_d  = (rd_s && !bad_s) ? rd_val_s : {DATA_WIDTH{1'b0}};
`ifdef CFG_REGBANK_SHADOW_EN
        shadow_d = shadow_q;
        for (int i = 0; i < N_CTRL_WORDS; i++) begin
            shadow_d[i] = (ctrl_wr_s && addr_ext_s == 64'(i))
                        ? merge_bytes(shadow_q[i], wdata, bit_mask_s) : shadow_q[i];
        end
        ctrl_d = (cmd_wr_s && wdata_m_s[DATA_WIDTH-1]) ? shadow_q : ctrl_q;
`else
        ctrl_d = ctrl_q;
        for (int i = 0; i < N_CTRL_WORDS; i++) begin
            ctrl_d[i] = (ctrl_wr_s && addr_ext_s == 64'(i))
                      ? merge_bytes(ctrl_q[i], wdata, bit_mask_s) : ctrl_q[i];
        end
`endif
    end

    // Main registers; reset drops any in-flight response immediately
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ctrl_q   <= '0;
            cmd_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            cmd_q    <= cmd_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    cfg_regbank_irq #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_EVT      (N_EVT)
    ) u_irq (
        .clk        (clk),
        .arst       (arst),
        .evt        (evt),
        .clr_we     (irqs_wr_s),
        .mask_we    (irqm_wr_s),
        .wbits      (wdata_m_s[N_EVT-1:0]),
        .bmask      (bit_mask_s[N_EVT-1:0]),
        .irq_status (irq_status_s),
        .irq_mask   (irq_mask_s),
        .irq        (irq)
    );

    assign gnt       = req;
    assign ctrl_vec  = ctrl_q;
    assign cmd_pulse = cmd_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule
